// File: rtl/nrsag_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nrsag_arbiter
// Brief    : Round-robin arbiter sharing one combinational 8-bit
//            non-reflecting sheep-and-goats core over a 2-stage pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module nrsag_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_di,
    input  logic [8*NREQ-1:0] req_ci,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_do,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy,
    output logic [CNTW-1:0]   op_count
);

    localparam int              c_ptr_w   = $clog2(NREQ);
    localparam int              c_cand_w  = c_ptr_w + 1;
    localparam logic [NREQ-1:0] c_one_hot = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};

    logic [c_ptr_w-1:0]  r_ptr;
    logic                r_s1_valid;
    logic [IDW-1:0]      r_s1_id;
    logic [7:0]          r_s1_di;
    logic [7:0]          r_s1_ci;
    logic                r_rsp_valid;
    logic [7:0]          r_rsp_do;
    logic [IDW-1:0]      r_rsp_id;
    logic [CNTW-1:0]     r_op_count;

    logic                w_s2_adv;
    logic                w_s1_adv;
    logic                w_gnt_found;
    logic [c_ptr_w-1:0]  w_gnt_idx;
    logic [c_cand_w-1:0] w_cand;
    logic                w_hs;
    logic [c_ptr_w-1:0]  w_ptr_next;
    logic [7:0]          w_sag;

    // Non-reflecting SAG: ci=0 bits packed low, ci=1 bits above, both in order.
    function automatic logic [7:0] f_sag(input logic [7:0] di, input logic [7:0] ci);
        logic [7:0] res;
        logic [3:0] pos;
        res = '0;
        pos = '0;
        for (int b = 0; b < 8; b++) begin
            if (!ci[b]) begin
                res[pos[2:0]] = di[b];
                pos           = pos + 4'd1;
            end
        end
        for (int b = 0; b < 8; b++) begin
            if (ci[b]) begin
                res[pos[2:0]] = di[b];
                pos           = pos + 4'd1;
            end
        end
        return res;
    endfunction

    assign w_s2_adv = !r_rsp_valid || rsp_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // Scan from the pointer upward; wrap by compare so non-power-of-2 NREQ works.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_ptr} + c_cand_w'(k);
            if (w_cand >= c_cand_w'(NREQ)) begin
                w_cand = w_cand - c_cand_w'(NREQ);
            end
            if (!w_gnt_found && req_valid[w_cand[c_ptr_w-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand[c_ptr_w-1:0];
            end
        end
    end

    assign w_hs       = w_gnt_found && w_s1_adv && !rst;
    assign req_ready  = w_hs ? (c_one_hot << w_gnt_idx) : '0;
    assign w_ptr_next = (w_gnt_idx == c_ptr_w'(NREQ - 1)) ? '0 : (w_gnt_idx + c_ptr_w'(1));
    assign w_sag      = f_sag(r_s1_di, r_s1_ci);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_id     <= '0;
            r_s1_di     <= '0;
            r_s1_ci     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_do    <= '0;
            r_rsp_id    <= '0;
            r_op_count  <= '0;
        end else begin
            if (r_rsp_valid && rsp_ready) begin
                r_op_count <= r_op_count + c_cnt_one;
            end
            // Bubbles advance valid only; payload keeps its last value.
            if (w_s2_adv) begin
                r_rsp_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_rsp_do <= w_sag;
                    r_rsp_id <= r_s1_id;
                end
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_hs;
                if (w_hs) begin
                    r_s1_id <= IDW'(w_gnt_idx);
                    r_s1_di <= req_di[8*w_gnt_idx +: 8];
                    r_s1_ci <= req_ci[8*w_gnt_idx +: 8];
                    r_ptr   <= w_ptr_next;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_do    = r_rsp_do;
    assign rsp_id    = r_rsp_id;
    assign op_count  = r_op_count;
    assign busy      = (r_s1_valid || r_rsp_valid) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_nrsag_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nrsag_arbiter
// Brief    : Self-checking bench for nrsag_arbiter: directed scenarios plus
//            random traffic compared against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nrsag_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_di;
    logic [8*NREQ-1:0] req_ci;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_do;
    logic [IDW-1:0]    rsp_id;
    logic              busy;
    logic [CNTW-1:0]   op_count;

    nrsag_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_di    (req_di),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_do    (rsp_do),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] di_a [NREQ];
    logic [7:0] ci_a [NREQ];

    // Reference model: pipeline slots, rotation pointer, delivered count
    int         m_ptr;
    bit         m_s1_v;
    logic [7:0] m_s1_di;
    logic [7:0] m_s1_ci;
    int         m_s1_id;
    bit         m_out_v;
    logic [7:0] m_out_do;
    int         m_out_id;
    int         m_count;
    int         m_gnt;
    int         n_acc;
    logic [NREQ-1:0] obs_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_sag(input logic [7:0] di, input logic [7:0] ci);
        bit         q[$];
        logic [7:0] r;
        for (int i = 0; i < 8; i++) if (!ci[i]) q.push_back(di[i]);
        for (int i = 0; i < 8; i++) if (ci[i])  q.push_back(di[i]);
        for (int i = 0; i < 8; i++) r[i] = q[i];
        return r;
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_s1_v   = 0;
        m_s1_di  = '0;
        m_s1_ci  = '0;
        m_s1_id  = 0;
        m_out_v  = 0;
        m_out_do = '0;
        m_out_id = 0;
        m_count  = 0;
    endtask

    // One clock: drive inputs, check at negedge, advance model, return #1 after posedge.
    task automatic step(input logic [NREQ-1:0] v, input logic rr);
        bit              s2_adv;
        bit              s1_adv;
        logic [NREQ-1:0] exp_ready;
        for (int i = 0; i < NREQ; i++) begin
            req_di[8*i +: 8] = di_a[i];
            req_ci[8*i +: 8] = ci_a[i];
        end
        req_valid = v;
        rsp_ready = rr;
        s2_adv = !m_out_v || rr;
        s1_adv = !m_s1_v || s2_adv;
        m_gnt  = -1;
        if (!rst && s1_adv) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (m_gnt < 0 && v[c]) m_gnt = c;
            end
        end
        exp_ready = (m_gnt >= 0) ? (NREQ'(1) << m_gnt) : '0;

        @(negedge clk);
        obs_ready = req_ready;
        check("req_ready", req_ready, exp_ready);
        check("busy", busy, (!rst && (m_s1_v || m_out_v)));
        check("rsp_valid", rsp_valid, m_out_v);
        check("rsp_do", rsp_do, m_out_do);
        check("rsp_id", rsp_id, m_out_id);
        check("op_count", op_count, m_count % (1 << CNTW));

        if (rst) begin
            model_reset();
        end else begin
            if (m_out_v && rr) m_count++;
            if (s2_adv) begin
                m_out_v = m_s1_v;
                if (m_s1_v) begin
                    m_out_do = ref_sag(m_s1_di, m_s1_ci);
                    m_out_id = m_s1_id;
                end
            end
            if (s1_adv) begin
                m_s1_v = (m_gnt >= 0);
                if (m_gnt >= 0) begin
                    m_s1_di = di_a[m_gnt];
                    m_s1_ci = ci_a[m_gnt];
                    m_s1_id = m_gnt;
                    m_ptr   = (m_gnt + 1) % NREQ;
                    n_acc++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input int idx, input logic [7:0] di, input logic [7:0] ci,
                             input logic [7:0] exp, input string tag);
        di_a[idx] = di;
        ci_a[idx] = ci;
        step(NREQ'(1) << idx, 1'b1);
        check({tag, "_gnt"}, obs_ready, NREQ'(1) << idx);
        step('0, 1'b1);
        check({tag, "_vld"}, rsp_valid, 1);
        check({tag, "_do"}, rsp_do, exp);
        check({tag, "_id"}, rsp_id, idx);
        step('0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step('0, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] v;
        logic [7:0]      held_do;
        logic [IDW-1:0]  held_id;
        int              cyc;
        int              start;

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_di    = '0;
        req_ci    = '0;
        n_acc     = 0;
        for (int i = 0; i < NREQ; i++) begin
            di_a[i] = '0;
            ci_a[i] = '0;
        end
        model_reset();
        @(posedge clk);
        #1;
        step('0, 1'b0);
        rst = 1'b0;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_rsp_do", rsp_do, 0);
        check("rst_busy", busy, 0);

        // Single op and fixed SAG patterns
        single_op(0, 8'hA5, 8'h55, 8'h3C, "single");
        check("single_count", op_count, 1);
        single_op(1, 8'h6B, 8'h00, 8'h6B, "ident");
        single_op(2, 8'hA5, 8'hF0, 8'hA5, "hi_mask");
        single_op(3, 8'hA5, 8'h0F, 8'h5A, "lo_mask");

        // All requesters valid: strict rotation, one grant per cycle
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step('1, 1'b1);
            check("rr_gnt", obs_ready, NREQ'(1) << (i % NREQ));
            if (i >= 1) begin
                check("rr_rsp_valid", rsp_valid, 1);
                check("rr_rsp_id", rsp_id, (i - 1) % NREQ);
            end
            if (m_gnt >= 0) begin
                di_a[m_gnt] = 8'($urandom);
                ci_a[m_gnt] = 8'($urandom);
            end
        end

        // Backpressure with a full pipe
        held_do = rsp_do;
        held_id = rsp_id;
        for (int i = 0; i < 5; i++) begin
            step('1, 1'b0);
            check("bp_ready", obs_ready, 0);
            check("bp_do_stable", rsp_do, held_do);
            check("bp_id_stable", rsp_id, held_id);
        end
        step('1, 1'b1);
        check("bp_rel1_id", rsp_id, (int'(held_id) + 1) % NREQ);
        step('1, 1'b1);
        check("bp_rel2_id", rsp_id, (int'(held_id) + 2) % NREQ);

        // Reset with S1 and S2 full
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        step('1, 1'b1);
        check("rst_hi_ready", obs_ready, 0);
        rst = 1'b0;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", op_count, 0);
        step(4'b0110, 1'b1);
        check("post_rst_gnt", obs_ready, 4'b0010);

        // Sparse fairness from pointer 2
        do_reset();
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b1001, 1'b1);
        check("sparse_g0", obs_ready, 4'b1000);
        step(4'b1001, 1'b1);
        check("sparse_g1", obs_ready, 4'b0001);
        step(4'b1001, 1'b1);
        check("sparse_g2", obs_ready, 4'b1000);
        step('0, 1'b1);
        step('0, 1'b1);

        // Random traffic against the model
        v     = '0;
        cyc   = 0;
        start = n_acc;
        while ((n_acc - start) < 10000 && cyc < 60000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 99) < 55) begin
                    v[i]    = 1'b1;
                    di_a[i] = 8'($urandom);
                    ci_a[i] = 8'($urandom);
                end
            end
            step(v, $urandom_range(0, 99) < 70);
            if (m_gnt >= 0) v[m_gnt] = 1'b0;
            cyc++;
        end
        check("rand_ops_done", ((n_acc - start) >= 10000), 1);
        for (int i = 0; i < 3; i++) step('0, 1'b1);
        check("drain_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
